// File: rtl/reg_write_arbiter_if.sv
// Requester-side bus of the shared-register write arbiter: per-requester
// write requests, data and lock requests in, grant/ack/owner/contents out.
interface reg_write_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] wdata;
    logic [3:0]         lock;
    logic [3:0]         grant;
    logic               ack;
    logic [1:0]         owner;
    logic [WIDTH-1:0]   dout;

    // Producer side: drives requests and data, observes the handshake.
    modport master (
        output req, wdata, lock,
        input  grant, ack, owner, dout
    );

    // Arbiter side: samples requests, returns grant and register contents.
    modport slave (
        input  req, wdata, lock,
        output grant, ack, owner, dout
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter sharing one WIDTH-bit holding register between
// four requesters. A requester whose grant bit is high is masked for that
// cycle, so one req/grant handshake produces exactly one write.
// Optional feature: define REG_ARB_LOCK_EN to let a winner holding its lock
// bit keep exclusive ownership (LOCKED state) until it drops the lock.
module reg_write_arbiter #(
    parameter int WIDTH = 8
) (
    input logic               clk,
    input logic               reset,
    reg_write_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANTED = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       owner_q, owner_d;
    logic [3:0]       grant_q, grant_d;
    logic             ack_q;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic [WIDTH-1:0] slot [4];
    logic [3:0]       eligible;
    logic [1:0]       base;
    logic [1:0]       cand;
    logic [1:0]       win;
    logic             found;

`ifdef REG_ARB_LOCK_EN
    logic             stay_locked;
`else
    logic             unused_lock;
    assign unused_lock = ^bus.lock;
`endif

    // Split the packed write-data bus into one word per requester.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            slot[i] = bus.wdata[i*WIDTH +: WIDTH];
        end
    end

    // Pick the winner searching from the pointer and compute the next register values.
    always_comb begin
        eligible = bus.req & ~grant_q;
        base     = ptr_q;
        cand     = 2'd0;
        win      = 2'd0;
        found    = 1'b0;
        state_d  = IDLE;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        grant_d  = 4'b0000;
        dout_d   = dout_q;
`ifdef REG_ARB_LOCK_EN
        stay_locked = 1'b0;
        if (state_q == LOCKED) begin
            if (bus.lock[owner_q]) begin
                stay_locked = 1'b1;
                eligible    = eligible & (4'b0001 << owner_q);
            end else begin
                base = owner_q + 2'd1;
            end
        end
`endif
        for (int i = 0; i < 4; i++) begin
            cand = base + i[1:0];
            if (!found && eligible[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        if (found) begin
            grant_d = 4'b0001 << win;
            dout_d  = slot[win];
            owner_d = win;
            ptr_d   = win + 2'd1;
            state_d = GRANTED;
`ifdef REG_ARB_LOCK_EN
            if (bus.lock[win]) begin
                state_d = LOCKED;
                ptr_d   = ptr_q;
            end
`endif
        end else begin
`ifdef REG_ARB_LOCK_EN
            if (stay_locked) begin
                state_d = LOCKED;
            end else if (state_q == LOCKED) begin
                ptr_d = base;
            end
`endif
        end
    end

    // Register state, pointer and all outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            owner_q <= 2'd0;
            grant_q <= 4'b0000;
            ack_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            grant_q <= grant_d;
            ack_q   <= |grant_d;
            dout_q  <= dout_d;
        end
    end

    assign bus.grant = grant_q;
    assign bus.ack   = ack_q;
    assign bus.owner = owner_q;
    assign bus.dout  = dout_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed self-checking bench for reg_write_arbiter: reset, single
// requester masking, round-robin wrap, pointer fairness, idle hold and the
// lock scenario (expectations follow REG_ARB_LOCK_EN when defined).
module tb_reg_write_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [3:0] exp_grant [5];

    reg_write_arbiter_if #(.WIDTH(8)) bus ();

    reg_write_arbiter #(.WIDTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [7:0] d, input logic [1:0] o);
        check_output({tag, " grant"}, 32'(bus.grant), 32'(g));
        check_output({tag, " ack"},   32'(bus.ack),   32'(|g));
        check_output({tag, " dout"},  32'(bus.dout),  32'(d));
        check_output({tag, " owner"}, 32'(bus.owner), 32'(o));
    endtask

    // Directed stimulus sequence.
    initial begin
        checks    = 0;
        errors    = 0;
        reset     = 1'b0;
        bus.req   = 4'b0000;
        bus.lock  = 4'b0000;
        bus.wdata = '0;

        tick();
        tick();
        check_all("reset", 4'b0000, 8'h00, 2'd0);
        reset = 1'b1;
        tick();
        check_all("idle after reset", 4'b0000, 8'h00, 2'd0);

        // Single requester 2: writes on alternate cycles.
        bus.wdata = {8'h00, 8'h0A, 8'h00, 8'h00};
        bus.req   = 4'b0100;
        tick();
        check_all("single c1", 4'b0100, 8'h0A, 2'd2);
        tick();
        check_all("single c2", 4'b0000, 8'h0A, 2'd2);
        tick();
        check_all("single c3", 4'b0100, 8'h0A, 2'd2);
        tick();
        check_all("single c4", 4'b0000, 8'h0A, 2'd2);

        // Pointer is now 3: all requesting grants requester 3, then reset mid-cycle.
        bus.wdata = {8'h33, 8'h23, 8'h13, 8'h03};
        bus.req   = 4'b1111;
        tick();
        check_all("pre-reset", 4'b1000, 8'h33, 2'd3);
        #3;
        reset = 1'b0;
        #1;
        check_all("async reset", 4'b0000, 8'h00, 2'd0);
        tick();
        check_all("held reset", 4'b0000, 8'h00, 2'd0);
        reset = 1'b1;

        // Round-robin wrap from pointer 0.
        tick();
        check_all("rr 0", 4'b0001, 8'h03, 2'd0);
        tick();
        check_all("rr 1", 4'b0010, 8'h13, 2'd1);
        tick();
        check_all("rr 2", 4'b0100, 8'h23, 2'd2);
        tick();
        check_all("rr 3", 4'b1000, 8'h33, 2'd3);
        tick();
        check_all("rr wrap", 4'b0001, 8'h03, 2'd0);

        // Pointer fairness around the wrap.
        bus.req = 4'b1000;
        tick();
        check_all("fair r3", 4'b1000, 8'h33, 2'd3);
        bus.req = 4'b1001;
        tick();
        check_all("fair wrap", 4'b0001, 8'h03, 2'd0);
        tick();
        check_all("fair next", 4'b1000, 8'h33, 2'd3);

        // Idle hold after writing 5A from requester 1 (pointer is 0 here).
        bus.wdata = {8'h33, 8'h23, 8'h5A, 8'h03};
        bus.req   = 4'b0010;
        tick();
        check_all("write 5A", 4'b0010, 8'h5A, 2'd1);
        bus.req = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_all("idle hold", 4'b0000, 8'h5A, 2'd1);
        end

        // Lock scenario: pointer is 2, so requester 0 first moves it to 1.
        bus.wdata = {8'h44, 8'h23, 8'h11, 8'h00};
        bus.req   = 4'b0001;
        tick();
        check_all("lock setup", 4'b0001, 8'h00, 2'd0);
        bus.req  = 4'b1011;
        bus.lock = 4'b0010;
`ifdef REG_ARB_LOCK_EN
        exp_grant = '{4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b1000};
`else
        exp_grant = '{4'b0010, 4'b1000, 4'b0001, 4'b0010, 4'b1000};
`endif
        for (int i = 0; i < 5; i++) begin
            if (i == 4) begin
                bus.lock = 4'b0000;
            end
            tick();
            check_output($sformatf("lock seq %0d grant", i), 32'(bus.grant), 32'(exp_grant[i]));
            check_output($sformatf("lock seq %0d ack", i), 32'(bus.ack), 32'(|exp_grant[i]));
        end
        check_output("lock end owner", 32'(bus.owner), 32'd3);
        check_output("lock end dout", 32'(bus.dout), 32'h44);

        bus.req = 4'b0000;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
